// File: rtl/register_file_scoreboard_pkg.sv
// Shared sizing constants and helpers for the register file / pending-write scoreboard.
package register_file_scoreboard_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_COUNT     = 32;
    localparam int unsigned REG_ADDR_BITS = $clog2(REG_COUNT);
    localparam int unsigned PEND_BITS     = 2;

    localparam logic [REG_ADDR_BITS-1:0] ZERO_REG = '0;
    localparam logic [PEND_BITS-1:0]     PEND_MAX = '1;

    // A source is still busy unless its only outstanding write retires this cycle.
    function automatic logic pend_busy(input logic [PEND_BITS-1:0] cnt, input logic retiring);
        return (cnt > PEND_BITS'(1)) || ((cnt == PEND_BITS'(1)) && !retiring);
    endfunction

endpackage

// File: rtl/register_file_scoreboard_if.sv
// Write-back, read-port and issue signals between the pipeline and the register file.
interface register_file_scoreboard_if;
    import register_file_scoreboard_pkg::*;

    logic                     wb_we;
    logic [REG_ADDR_BITS-1:0] wb_rd;
    logic [XLEN-1:0]          wb_result;
    logic [REG_ADDR_BITS-1:0] rs1_addr;
    logic [REG_ADDR_BITS-1:0] rs2_addr;
    logic [XLEN-1:0]          rs1_data;
    logic [XLEN-1:0]          rs2_data;
    logic                     issue_valid;
    logic                     issue_writes;
    logic [REG_ADDR_BITS-1:0] issue_rd;
    logic                     issue_uses_rs1;
    logic                     issue_uses_rs2;
    logic                     flush;
    logic                     stall;

    modport master (
        output wb_we, wb_rd, wb_result, rs1_addr, rs2_addr,
               issue_valid, issue_writes, issue_rd, issue_uses_rs1, issue_uses_rs2, flush,
        input  rs1_data, rs2_data, stall
    );

    modport slave (
        input  wb_we, wb_rd, wb_result, rs1_addr, rs2_addr,
               issue_valid, issue_writes, issue_rd, issue_uses_rs1, issue_uses_rs2, flush,
        output rs1_data, rs2_data, stall
    );

endinterface

// File: rtl/register_file_scoreboard_pending_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module pending_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic             dec_eff;
    logic [WIDTH-1:0] count_next;

    assign dec_eff = dec && (count != '0);

    // On clear the surviving issue still lands on top of the zeroed count.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = inc ? WIDTH'(1) : '0;
        end else if (inc && !dec_eff && (count != '1)) begin
            count_next = count + WIDTH'(1);
        end else if (dec_eff && !inc) begin
            count_next = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/register_file_scoreboard.sv
// Architectural integer register file with write-through read ports and a per-register
// pending-write scoreboard that raises stall on RAW hazards and counter overflow.
module register_file_scoreboard
    import register_file_scoreboard_pkg::*;
(
    input logic                      clk,
    input logic                      rst_n,
    register_file_scoreboard_if.slave rf
);

    logic [XLEN-1:0]      regs [REG_COUNT];
    logic [PEND_BITS-1:0] pend [REG_COUNT];

    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
    logic accept_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.wb_we && (rf.wb_rd != ZERO_REG)) begin
            regs[rf.wb_rd] <= rf.wb_result;
        end
    end

    always_comb begin
        rf.rs1_data = regs[rf.rs1_addr];
        if (rf.rs1_addr == ZERO_REG) begin
            rf.rs1_data = '0;
        end else if (rf.wb_we && (rf.wb_rd == rf.rs1_addr)) begin
            rf.rs1_data = rf.wb_result;
        end
    end

    always_comb begin
        rf.rs2_data = regs[rf.rs2_addr];
        if (rf.rs2_addr == ZERO_REG) begin
            rf.rs2_data = '0;
        end else if (rf.wb_we && (rf.wb_rd == rf.rs2_addr)) begin
            rf.rs2_data = rf.wb_result;
        end
    end

    always_comb begin
        rs1_busy = (rf.rs1_addr != ZERO_REG) &&
                   pend_busy(pend[rf.rs1_addr], rf.wb_we && (rf.wb_rd == rf.rs1_addr));
        rs2_busy = (rf.rs2_addr != ZERO_REG) &&
                   pend_busy(pend[rf.rs2_addr], rf.wb_we && (rf.wb_rd == rf.rs2_addr));
        // A full destination may still accept one more issue if a write-back frees a slot.
        rd_full  = (rf.issue_rd != ZERO_REG) && (pend[rf.issue_rd] == PEND_MAX) &&
                   !(rf.wb_we && (rf.wb_rd == rf.issue_rd));
        rf.stall = rf.issue_valid && ((rf.issue_uses_rs1 && rs1_busy) ||
                                      (rf.issue_uses_rs2 && rs2_busy) ||
                                      (rf.issue_writes   && rd_full));
        accept_inc = rf.issue_valid && !rf.stall && rf.issue_writes && (rf.issue_rd != ZERO_REG);
    end

    assign pend[0] = '0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_pend
        pending_counter #(
            .WIDTH(PEND_BITS)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (accept_inc && (rf.issue_rd == REG_ADDR_BITS'(r))),
            .dec  (rf.wb_we && (rf.wb_rd == REG_ADDR_BITS'(r))),
            .clear(rf.flush),
            .count(pend[r])
        );
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomized and directed bench for register_file_scoreboard against a behavioural model.
module tb_register_file_scoreboard;

    logic clk;
    logic rst_n;

    register_file_scoreboard_if rf_if ();

    register_file_scoreboard dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rf   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int          m_pend [32];
    logic [31:0] m_regs [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0;
            m_regs[i] = 32'h0;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rf_if.wb_we && rf_if.wb_rd == a) return rf_if.wb_result;
        return m_regs[a];
    endfunction

    function automatic int eff(input logic [4:0] s);
        int hit;
        hit = (rf_if.wb_we && rf_if.wb_rd == s && m_pend[s] != 0) ? 1 : 0;
        return m_pend[s] - hit;
    endfunction

    function automatic logic exp_stall();
        logic st;
        st = 1'b0;
        if (rf_if.issue_uses_rs1 && rf_if.rs1_addr != 0 && eff(rf_if.rs1_addr) != 0) st = 1'b1;
        if (rf_if.issue_uses_rs2 && rf_if.rs2_addr != 0 && eff(rf_if.rs2_addr) != 0) st = 1'b1;
        if (rf_if.issue_writes && rf_if.issue_rd != 0 && m_pend[rf_if.issue_rd] == 3 &&
            !(rf_if.wb_we && rf_if.wb_rd == rf_if.issue_rd)) st = 1'b1;
        return rf_if.issue_valid && st;
    endfunction

    task automatic cycle(input string tag, input logic we, input logic [4:0] wrd,
                         input logic [31:0] res, input logic [4:0] a1, input logic [4:0] a2,
                         input logic iv, input logic iw, input logic [4:0] ird,
                         input logic u1, input logic u2, input logic fl);
        logic s;
        logic inc;
        logic dec;
        @(negedge clk);
        rf_if.wb_we          = we;
        rf_if.wb_rd          = wrd;
        rf_if.wb_result      = res;
        rf_if.rs1_addr       = a1;
        rf_if.rs2_addr       = a2;
        rf_if.issue_valid    = iv;
        rf_if.issue_writes   = iw;
        rf_if.issue_rd       = ird;
        rf_if.issue_uses_rs1 = u1;
        rf_if.issue_uses_rs2 = u2;
        rf_if.flush          = fl;
        #1;
        check_eq({tag, "/rs1"}, rf_if.rs1_data, exp_read(a1));
        check_eq({tag, "/rs2"}, rf_if.rs2_data, exp_read(a2));
        s = exp_stall();
        check_eq({tag, "/stall"}, {31'h0, rf_if.stall}, {31'h0, s});
        inc = iv && !s && iw && ird != 0;
        dec = we && wrd != 0 && m_pend[wrd] != 0;
        @(posedge clk);
        if (we && wrd != 0) m_regs[wrd] = res;
        if (fl) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else if (dec) begin
            m_pend[wrd] = m_pend[wrd] - 1;
        end
        if (inc) m_pend[ird] = m_pend[ird] + 1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic issue_wr(input string tag, input logic [4:0] rd);
        cycle(tag, 0, 0, 0, 0, 0, 1, 1, rd, 0, 0, 0);
    endtask
    task automatic probe_rs1(input string tag, input logic [4:0] a);
        cycle(tag, 0, 0, 0, a, 0, 1, 0, 0, 1, 0, 0);
    endtask
    task automatic wb(input string tag, input logic [4:0] rd, input logic [31:0] d);
        cycle(tag, 1, rd, d, rd, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rf_if.wb_we          = 1'b0;
        rf_if.rs1_addr       = 5'd3;
        rf_if.rs2_addr       = 5'd6;
        rf_if.issue_valid    = 1'b1;
        rf_if.issue_writes   = 1'b1;
        rf_if.issue_rd       = 5'd6;
        rf_if.issue_uses_rs1 = 1'b1;
        rf_if.issue_uses_rs2 = 1'b1;
        rf_if.flush          = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq({tag, "/rs1"}, rf_if.rs1_data, 32'h0);
        check_eq({tag, "/rs2"}, rf_if.rs2_data, 32'h0);
        check_eq({tag, "/stall"}, {31'h0, rf_if.stall}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        model_reset();
        do_reset("reset_init");

        // x0 is never written and never bypassed
        cycle("x0_write", 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("x0_read");

        // Same-cycle bypass, then storage
        cycle("bypass5", 1, 5, 32'h12345678, 5, 0, 0, 0, 0, 0, 0, 0);
        cycle("stored5", 0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0);

        // RAW stall on x3 until its write-back
        issue_wr("raw_issue", 3);
        for (int i = 0; i < 3; i++) probe_rs1("raw_wait", 3);
        cycle("raw_wb", 1, 3, 32'hA5A5_0003, 3, 0, 1, 0, 0, 1, 0, 0);
        probe_rs1("raw_clear", 3);

        // Simultaneous inc/dec on x7
        issue_wr("incdec_issue", 7);
        cycle("incdec_both", 1, 7, 32'h7777_0001, 0, 0, 1, 1, 7, 0, 0, 0);
        probe_rs1("incdec_hold", 7);
        wb("incdec_wb", 7, 32'h7777_0002);
        probe_rs1("incdec_zero", 7);

        // Saturation on x9
        for (int i = 0; i < 3; i++) issue_wr("sat_fill", 9);
        issue_wr("sat_full", 9);
        cycle("sat_swap", 1, 9, 32'h9999_0000, 0, 0, 1, 1, 9, 0, 0, 0);
        issue_wr("sat_still_full", 9);
        for (int i = 0; i < 3; i++) wb("sat_drain", 9, 32'h9999_0001 + i);
        probe_rs1("sat_empty", 9);

        // Flush with a surviving issue
        issue_wr("flush_p2a", 2);
        issue_wr("flush_p2b", 2);
        issue_wr("flush_p4", 4);
        cycle("flush_go", 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 1);
        probe_rs1("flush_x2", 2);
        probe_rs1("flush_x4", 4);
        wb("flush_wb2", 2, 32'h2222_2222);
        probe_rs1("flush_x2_data", 2);
        wb("flush_wb4", 4, 32'h4444_4444);

        // Reset mid-run discards pending state and data
        wb("pre_rst_w3", 3, 32'h3333_3333);
        issue_wr("pre_rst_i3", 3);
        issue_wr("pre_rst_i6", 6);
        issue_wr("pre_rst_i6b", 6);
        do_reset("reset_mid");
        probe_rs1("post_rst_x3", 3);
        cycle("post_rst_x6", 0, 0, 0, 6, 3, 1, 1, 6, 1, 1, 0);

        // Randomized traffic biased to a few registers so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wrd, a1, a2, ird;
            logic we, iv, iw, u1, u2, fl;
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rand_reset");
            end else begin
                wrd = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                a1  = 5'($urandom_range(0, 7));
                a2  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                ird = 5'($urandom_range(0, 7));
                we  = ($urandom_range(0, 2) == 0);
                iv  = ($urandom_range(0, 3) != 0);
                iw  = ($urandom_range(0, 2) != 0);
                u1  = ($urandom_range(0, 1) == 0);
                u2  = ($urandom_range(0, 1) == 0);
                fl  = ($urandom_range(0, 39) == 0);
                cycle("rand", we, wrd, $urandom, a1, a2, iv, iw, ird, u1, u2, fl);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Consumer end of the write-back result path.
- Holds the architectural integer register file, which the write-back stage writes.
- Serves two combinational read ports to decode, with write-through bypass.
- Tracks pending writes per register in a counter scoreboard so decode can stall on RAW hazards and on pending-write overflow.

Parameters:
- XLEN, 32, data width of registers and result bus.
- REG_COUNT, 32, number of architectural registers; x0 is hardwired to zero.
- ADDR_BITS, 5, register index width, equal to clog2(REG_COUNT).
- PEND_BITS, 2, width of each per-register pending-write counter; saturates at 2**PEND_BITS-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_we  in  1  write-back valid with register write.
- wb_rd  in  ADDR_BITS  write-back destination index.
- wb_result  in  XLEN  write-back data, i.e. the selected result.
- rs1_addr  in  ADDR_BITS  read port 1 index.
- rs2_addr  in  ADDR_BITS  read port 2 index.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- issue_valid  in  1  decode is issuing an instruction this cycle (taken only if ~stall).
- issue_writes  in  1  issuing instruction writes rd.
- issue_rd  in  ADDR_BITS  issuing instruction's destination.
- issue_uses_rs1  in  1  issuing instruction reads rs1_addr.
- issue_uses_rs2  in  1  issuing instruction reads rs2_addr.
- flush  in  1  synchronous clear of all pending counters (pipeline squash).
- stall  out  1  decode must hold; issue is not accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers 0; all pending counters 0. Consequently rs1_data=rs2_data=0 and stall=0 while in reset. Reset mid-operation discards all pending state; no write completes in the reset cycle.
- Write: on posedge, if wb_we and wb_rd!=0, then reg[wb_rd] <= wb_result. Writes to x0 are dropped.
- Read: rsN_data is 0 if rsN_addr==0.
  - Else if wb_we and wb_rd==rsN_addr, rsN_data = wb_result (write-through bypass, same-cycle).
  - Else rsN_data = reg[rsN_addr].
  - Zero latency.
- Effective pending count for source s: eff(s) = pend[s] - (wb_we && wb_rd==s && pend[s]!=0 ? 1 : 0).
- stall = issue_valid && any of the following:
  - issue_uses_rs1 && rs1_addr!=0 && eff(rs1_addr)!=0;
  - issue_uses_rs2 && rs2_addr!=0 && eff(rs2_addr)!=0;
  - issue_writes && issue_rd!=0 && pend[issue_rd]==MAX && !(wb_we && wb_rd==issue_rd).
- Accepted issue: inc = issue_valid && !stall && issue_writes && issue_rd!=0.
- Decrement: dec = wb_we && wb_rd!=0 && pend[wb_rd]!=0. Write-back to a register with count 0 still writes data and leaves the counter at 0; no underflow.
- Counter update per register r:
  - inc only: +1.
  - dec only: -1.
  - both same r: unchanged.
  - inc and dec on different registers: both apply.
- flush: all counters <= 0. If flush coincides with an accepted issue, the issue's increment still applies after the clear (the issuing instruction is the surviving one). The data write from wb_we still occurs.
- Pending counter for x0 is always 0; issue_rd=0 and wb_rd=0 never change counters.
- No overflow: the stall rule prevents inc at MAX unless a same-register dec coincides.

Decomposition:
- Shared constants header, extended with: REG_ADDR_BITS, REG_COUNT, PEND_BITS, and a zero-register index constant.
- One natural sub-module, pending_counter: single saturating up/down counter with inc, dec, clear, and async active-low reset. It is instantiated REG_COUNT-1 times via generate; x0 is tied to 0.
- Register array, bypass muxes and stall logic stay in the top module.

Test Plan:
- Reset and x0:
  - Assert rst_n=0 mid-run with pending counts nonzero, release → all reads return 0, stall=0.
  - Write wb_rd=0, wb_result=0xDEADBEEF → read x0 = 0.
- Bypass:
  - wb_we=1, wb_rd=5, wb_result=0x12345678 while rs1_addr=5 → rs1_data=0x12345678 same cycle.
  - Next cycle, wb_we=0 → still 0x12345678 from storage.
- RAW stall:
  - Issue writes rd=3 (pend[3]=1).
  - Next issue uses rs1=3 → stall=1 each cycle until wb_we with wb_rd=3.
  - In that write-back cycle stall=0, rs1_data is bypassed, and pend[3] returns to 0.
- Simultaneous inc/dec:
  - pend[7]=1; same cycle issue rd=7 accepted and wb_rd=7 → pend[7] stays 1.
  - A following write-back to 7 → pend[7]=0.
- Saturation:
  - Three accepted issues to rd=9 → pend[9]=3.
  - Fourth issue to rd=9 without write-back → stall=1.
  - Same issue coinciding with wb_rd=9 → accepted, pend[9]=3.
- Flush:
  - pend[2]=2, pend[4]=1; flush with an accepted issue rd=4 → pend[2]=0, pend[4]=1.
  - Write-back to x2 with count 0 → data written, counter stays 0.
